// File: rtl/alarm_clk_rtl.sv
// 24-hour alarm clock core: keypad entry buffer, current and alarm time
// registers, alarm match detection and registered ASCII display digits.
module alarm_clk_rtl #(
  parameter int CLK_HZ        = 256,
  parameter int KEY_TIMEOUT_S = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alarm_button,
  input  logic       time_button,
  input  logic       fast_watch,
  input  logic [3:0] key,
  output logic       sound_a,
  output logic [7:0] display_ms_hr,
  output logic [7:0] display_ls_hr,
  output logic [7:0] display_ms_min,
  output logic [7:0] display_ls_min
);

  localparam int PW        = $clog2(CLK_HZ);
  localparam int TO_CYCLES = KEY_TIMEOUT_S * CLK_HZ;
  localparam int TW        = $clog2(TO_CYCLES + 1);
  localparam logic [PW-1:0] PS_LAST = PW'(CLK_HZ - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CYCLES - 1);

  typedef enum logic {SHOW_TIME, ENTRY} state_t;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_prescale;
  logic [5:0]    r_sec, w_sec_nxt;
  logic [15:0]   r_time, w_time_nxt;
  logic [15:0]   r_alarm, w_alarm_nxt;
  logic [15:0]   r_buf, w_buf_nxt;
  logic          r_armed, w_armed_nxt;
  logic [3:0]    r_key_s;
  logic          r_prev_dig;
  logic [TW-1:0] r_timeout, w_timeout_nxt;
  logic          r_sound;
  logic [31:0]   r_disp, w_disp_nxt;
  logic          w_dig, w_press, w_tick, w_load_req;
  logic [15:0]   w_buf_shift;

  // Times are held as four BCD digits {hh_tens, hh_units, mm_tens, mm_units}.
  function automatic logic [15:0] incMinute(input logic [15:0] t);
    logic [3:0] ht, hu, mt, mu;
    {ht, hu, mt, mu} = t;
    if (mu != 4'd9) mu = mu + 4'd1;
    else begin
      mu = 4'd0;
      if (mt != 4'd5) mt = mt + 4'd1;
      else begin
        mt = 4'd0;
        if (ht == 4'd2 && hu == 4'd3) begin
          ht = 4'd0;
          hu = 4'd0;
        end else if (hu == 4'd9) begin
          hu = 4'd0;
          ht = ht + 4'd1;
        end else hu = hu + 4'd1;
      end
    end
    return {ht, hu, mt, mu};
  endfunction

  function automatic logic validTime(input logic [15:0] t);
    return ((t[15:12] < 4'd2) || (t[15:12] == 4'd2 && t[11:8] <= 4'd3)) &&
           (t[11:8] <= 4'd9) && (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
  endfunction

  function automatic logic [31:0] toAscii(input logic [15:0] t);
    return {4'h3, t[15:12], 4'h3, t[11:8], 4'h3, t[7:4], 4'h3, t[3:0]};
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= SHOW_TIME;
    else        r_state <= w_state_nxt;
  end

  // Display is registered from next-state values so it moves with the data.
  always_comb begin
    w_dig         = (r_key_s <= 4'd9);
    w_press       = w_dig && !r_prev_dig;
    w_tick        = (r_prescale == PS_LAST);
    w_load_req    = time_button || alarm_button;
    w_buf_shift   = {r_buf[11:0], r_key_s};
    w_state_nxt   = r_state;
    w_sec_nxt     = r_sec;
    w_time_nxt    = r_time;
    w_alarm_nxt   = r_alarm;
    w_buf_nxt     = r_buf;
    w_armed_nxt   = r_armed;
    w_timeout_nxt = r_timeout;
    w_disp_nxt    = toAscii(r_time);

    if (w_tick) begin
      if (fast_watch || r_sec == 6'd59) begin
        w_sec_nxt  = 6'd0;
        w_time_nxt = incMinute(r_time);
      end else w_sec_nxt = r_sec + 6'd1;
    end

    case (r_state)
      SHOW_TIME: begin
        if (w_press) begin
          w_state_nxt   = ENTRY;
          w_buf_nxt     = w_buf_shift;
          w_timeout_nxt = '0;
        end
      end
      ENTRY: begin
        if (w_load_req) begin
          if (validTime(r_buf)) begin
            if (time_button) begin
              w_time_nxt = r_buf;
              w_sec_nxt  = 6'd0;
            end else begin
              w_alarm_nxt = r_buf;
              w_armed_nxt = 1'b1;
            end
          end
          w_buf_nxt     = '0;
          w_state_nxt   = SHOW_TIME;
          w_timeout_nxt = '0;
        end else if (w_press) begin
          w_buf_nxt     = w_buf_shift;
          w_timeout_nxt = '0;
        end else if (r_timeout == TO_LAST) begin
          w_buf_nxt     = '0;
          w_state_nxt   = SHOW_TIME;
          w_timeout_nxt = '0;
        end else w_timeout_nxt = r_timeout + TW'(1);
      end
      default: w_state_nxt = SHOW_TIME;
    endcase

    if (w_state_nxt == ENTRY) w_disp_nxt = toAscii(w_buf_nxt);
    else if (alarm_button)    w_disp_nxt = toAscii(w_alarm_nxt);
    else                      w_disp_nxt = toAscii(w_time_nxt);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prescale <= '0;
      r_sec      <= '0;
      r_time     <= '0;
      r_alarm    <= '0;
      r_buf      <= '0;
      r_armed    <= 1'b0;
      r_key_s    <= 4'd10;
      r_prev_dig <= 1'b0;
      r_timeout  <= '0;
      r_sound    <= 1'b0;
      r_disp     <= 32'h3030_3030;
    end else begin
      r_prescale <= w_tick ? '0 : r_prescale + PW'(1);
      r_sec      <= w_sec_nxt;
      r_time     <= w_time_nxt;
      r_alarm    <= w_alarm_nxt;
      r_buf      <= w_buf_nxt;
      r_armed    <= w_armed_nxt;
      r_key_s    <= key;
      r_prev_dig <= w_dig;
      r_timeout  <= w_timeout_nxt;
      r_sound    <= r_armed && (r_time == r_alarm);
      r_disp     <= w_disp_nxt;
    end
  end

  assign sound_a        = r_sound;
  assign display_ms_hr  = r_disp[31:24];
  assign display_ls_hr  = r_disp[23:16];
  assign display_ms_min = r_disp[15:8];
  assign display_ls_min = r_disp[7:0];

endmodule

// File: tb/tb_alarm_clk_rtl.sv
// Self-checking bench for alarm_clk_rtl: directed scenarios plus randomized
// keypad/button traffic compared against a minutes-of-day reference model.
module tb_alarm_clk_rtl;

  localparam int CLK_HZ        = 4;
  localparam int KEY_TIMEOUT_S = 10;
  localparam int TO_CYC        = CLK_HZ * KEY_TIMEOUT_S;

  typedef struct packed {logic [3:0] k; logic t; logic a; logic f;} step_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        alarm_button = 1'b0, time_button = 1'b0, fast_watch = 1'b0;
  logic [3:0]  key = 4'd10;
  logic        sound_a;
  logic [7:0]  display_ms_hr, display_ls_hr, display_ms_min, display_ls_min;
  logic [31:0] dispObs;

  int checks = 0;
  int failures = 0;

  // Reference model state: times as minutes of the day, buffer as a 4-digit number.
  int  mCur, mSec, mAlarm, mBuf, mLastPress, mEdge, mS1, mS2;
  bit  mArmed, mEntry, expSound;
  logic [31:0] expDisp;

  alarm_clk_rtl #(.CLK_HZ(CLK_HZ), .KEY_TIMEOUT_S(KEY_TIMEOUT_S)) dut (
    .clk(clk), .reset(reset), .alarm_button(alarm_button),
    .time_button(time_button), .fast_watch(fast_watch), .key(key),
    .sound_a(sound_a), .display_ms_hr(display_ms_hr),
    .display_ls_hr(display_ls_hr), .display_ms_min(display_ms_min),
    .display_ls_min(display_ls_min)
  );

  assign dispObs = {display_ms_hr, display_ls_hr, display_ms_min, display_ls_min};

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired got=running exp=finished");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] digitsAscii(input int a, input int b, input int c, input int d);
    return {8'(48 + a), 8'(48 + b), 8'(48 + c), 8'(48 + d)};
  endfunction

  function automatic logic [31:0] timeAscii(input int t);
    return digitsAscii((t / 60) / 10, (t / 60) % 10, (t % 60) / 10, (t % 60) % 10);
  endfunction

  function automatic logic [31:0] bufAscii(input int b);
    return digitsAscii(b / 1000, (b / 100) % 10, (b / 10) % 10, b % 10);
  endfunction

  function automatic void modelInit();
    mCur = 0; mSec = 0; mAlarm = 0; mBuf = 0; mLastPress = 0; mEdge = 0;
    mS1 = 10; mS2 = 10; mArmed = 0; mEntry = 0; expSound = 0;
    expDisp = 32'h3030_3030;
  endfunction

  function automatic void modelStep();
    bit tick, press;
    int nCur, nSec, h, m;
    tick = (mEdge % CLK_HZ) == CLK_HZ - 1;
    press = (mS1 <= 9) && (mS2 > 9);
    expSound = mArmed && (mCur == mAlarm);
    nCur = mCur;
    nSec = mSec;
    if (tick) begin
      if (fast_watch || mSec == 59) begin
        nSec = 0;
        nCur = (mCur + 1) % 1440;
      end else nSec = mSec + 1;
    end
    if (!mEntry) begin
      if (press) begin
        mEntry = 1; mBuf = (mBuf * 10 + mS1) % 10000; mLastPress = mEdge;
      end
    end else if (time_button || alarm_button) begin
      h = mBuf / 100;
      m = mBuf % 100;
      if (h <= 23 && m <= 59) begin
        if (time_button) begin
          nCur = h * 60 + m; nSec = 0;
        end else begin
          mAlarm = h * 60 + m; mArmed = 1;
        end
      end
      mBuf = 0; mEntry = 0;
    end else if (press) begin
      mBuf = (mBuf * 10 + mS1) % 10000; mLastPress = mEdge;
    end else if (mEdge - mLastPress == TO_CYC) begin
      mBuf = 0; mEntry = 0;
    end
    mCur = nCur;
    mSec = nSec;
    if (mEntry)            expDisp = bufAscii(mBuf);
    else if (alarm_button) expDisp = timeAscii(mAlarm);
    else                   expDisp = timeAscii(mCur);
    mS2 = mS1;
    mS1 = int'(key);
    mEdge++;
  endfunction

  task automatic cycle();
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b0; key = 4'd10; time_button = 0; alarm_button = 0; fast_watch = 0;
    modelInit();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic pressKey(input int d);
    key = 4'(d);
    cycle();
    cycle();
    key = 4'd10;
    cycle();
  endtask

  task automatic enterDigits(input int a, input int b, input int c, input int d);
    pressKey(a); pressKey(b); pressKey(c); pressKey(d);
  endtask

  task automatic pulseButton(input bit t, input bit a);
    time_button = t; alarm_button = a;
    cycle();
    time_button = 0; alarm_button = 0;
  endtask

  task automatic test_reset();
    doReset();
    checks++;
    if (dispObs !== 32'h3030_3030) begin
      failures++; $display("[TB] FAIL reset_disp got=%h exp=%h", dispObs, 32'h3030_3030);
    end
    checks++;
    if (sound_a !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_sound got=%b exp=0", sound_a);
    end
    repeat (6) cycle();
    checks++;
    if (dispObs !== 32'h3030_3030) begin
      failures++; $display("[TB] FAIL reset_idle_disp got=%h exp=%h", dispObs, 32'h3030_3030);
    end
  endtask

  task automatic test_set_time();
    int h, m;
    doReset();
    enterDigits(1, 1, 1, 5);
    checks++;
    if (dispObs !== 32'h3131_3135) begin
      failures++; $display("[TB] FAIL entry_buffer got=%h exp=%h", dispObs, 32'h3131_3135);
    end
    pulseButton(1, 0);
    checks++;
    if (dispObs !== 32'h3131_3135) begin
      failures++; $display("[TB] FAIL set_1115 got=%h exp=%h", dispObs, 32'h3131_3135);
    end
    for (int i = 0; i < 4; i++) begin
      h = int'($urandom_range(0, 23));
      m = int'($urandom_range(0, 59));
      enterDigits(h / 10, h % 10, m / 10, m % 10);
      pulseButton(1, 0);
      checks++;
      if (dispObs !== timeAscii(h * 60 + m)) begin
        failures++; $display("[TB] FAIL set_random got=%h exp=%h", dispObs, timeAscii(h * 60 + m));
      end
    end
  endtask

  task automatic test_fast_wrap();
    doReset();
    enterDigits(1, 1, 1, 5);
    pulseButton(1, 0);
    fast_watch = 1;
    for (int i = 0; i < 180; i++) begin
      cycle();
      checks++;
      if (dispObs !== expDisp || dispObs[15:8] > 8'h35) begin
        failures++; $display("[TB] FAIL fast_run cyc=%0d got=%h exp=%h", i, dispObs, expDisp);
      end
    end
    checks++;
    if (dispObs !== 32'h3132_3030) begin
      failures++; $display("[TB] FAIL fast_1200 got=%h exp=%h", dispObs, 32'h3132_3030);
    end
    fast_watch = 0;
    enterDigits(2, 3, 5, 8);
    pulseButton(1, 0);
    fast_watch = 1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      checks++;
      if (dispObs !== expDisp) begin
        failures++; $display("[TB] FAIL day_wrap cyc=%0d got=%h exp=%h", i, dispObs, expDisp);
      end
    end
    checks++;
    if (dispObs !== 32'h3030_3031) begin
      failures++; $display("[TB] FAIL wrap_0001 got=%h exp=%h", dispObs, 32'h3030_3031);
    end
    fast_watch = 0;
  endtask

  task automatic test_alarm();
    bit sawOn, sawOff;
    sawOn = 0; sawOff = 0;
    doReset();
    enterDigits(1, 1, 3, 0);
    pulseButton(0, 1);
    checks++;
    if (dispObs !== 32'h3131_3330) begin
      failures++; $display("[TB] FAIL alarm_show got=%h exp=%h", dispObs, 32'h3131_3330);
    end
    enterDigits(1, 1, 2, 9);
    pulseButton(1, 0);
    fast_watch = 1;
    checks++;
    if (dispObs !== 32'h3131_3239 || sound_a !== 1'b0) begin
      failures++; $display("[TB] FAIL alarm_pre got=%h/%b exp=%h/0", dispObs, sound_a, 32'h3131_3239);
    end
    for (int i = 0; i < 24; i++) begin
      cycle();
      checks++;
      if (dispObs !== expDisp || sound_a !== expSound) begin
        failures++; $display("[TB] FAIL alarm_run cyc=%0d got=%h/%b exp=%h/%b", i, dispObs, sound_a, expDisp, expSound);
      end
      if (sound_a === 1'b1 && dispObs === 32'h3131_3330) sawOn = 1;
      if (sawOn && sound_a === 1'b0 && dispObs === 32'h3131_3331) sawOff = 1;
    end
    checks++;
    if (sawOn !== 1'b1 || sawOff !== 1'b1) begin
      failures++; $display("[TB] FAIL alarm_edges got=on%0d/off%0d exp=on1/off1", sawOn, sawOff);
    end
    fast_watch = 0;
    enterDigits(1, 1, 3, 0);
    pulseButton(1, 0);
    cycle();
    cycle();
    checks++;
    if (sound_a !== 1'b1) begin
      failures++; $display("[TB] FAIL alarm_match got=%b exp=1", sound_a);
    end
    enterDigits(1, 1, 4, 5);
    pulseButton(0, 1);
    cycle();
    checks++;
    if (sound_a !== 1'b0) begin
      failures++; $display("[TB] FAIL alarm_reload got=%b exp=0", sound_a);
    end
  endtask

  task automatic test_invalid();
    doReset();
    enterDigits(0, 7, 4, 2);
    pulseButton(1, 0);
    enterDigits(2, 5, 0, 0);
    pulseButton(1, 0);
    checks++;
    if (dispObs !== 32'h3037_3432) begin
      failures++; $display("[TB] FAIL invalid_hour got=%h exp=%h", dispObs, 32'h3037_3432);
    end
    enterDigits(1, 2, 6, 0);
    pulseButton(0, 1);
    alarm_button = 1;
    cycle();
    alarm_button = 0;
    checks++;
    if (dispObs !== 32'h3030_3030) begin
      failures++; $display("[TB] FAIL invalid_min_alarm got=%h exp=%h", dispObs, 32'h3030_3030);
    end
    cycle();
    checks++;
    if (dispObs !== expDisp || sound_a !== 1'b0) begin
      failures++; $display("[TB] FAIL invalid_after got=%h/%b exp=%h/0", dispObs, sound_a, expDisp);
    end
  endtask

  task automatic test_timeout();
    doReset();
    pressKey(1);
    pressKey(2);
    for (int i = 0; i < TO_CYC + 2; i++) begin
      cycle();
      checks++;
      if (dispObs !== expDisp) begin
        failures++; $display("[TB] FAIL timeout_run cyc=%0d got=%h exp=%h", i, dispObs, expDisp);
      end
    end
    checks++;
    if (dispObs !== 32'h3030_3030) begin
      failures++; $display("[TB] FAIL timeout_revert got=%h exp=%h", dispObs, 32'h3030_3030);
    end
    pulseButton(1, 0);
    cycle();
    checks++;
    if (dispObs !== 32'h3030_3030) begin
      failures++; $display("[TB] FAIL timeout_noload got=%h exp=%h", dispObs, 32'h3030_3030);
    end
  endtask

  task automatic test_both_buttons();
    doReset();
    enterDigits(0, 9, 4, 5);
    pulseButton(1, 1);
    cycle();
    checks++;
    if (dispObs !== 32'h3039_3435) begin
      failures++; $display("[TB] FAIL both_time got=%h exp=%h", dispObs, 32'h3039_3435);
    end
    alarm_button = 1;
    cycle();
    alarm_button = 0;
    checks++;
    if (dispObs !== 32'h3030_3030 || sound_a !== 1'b0) begin
      failures++; $display("[TB] FAIL both_alarm got=%h/%b exp=%h/0", dispObs, sound_a, 32'h3030_3030);
    end
  endtask

  task automatic test_async_reset();
    doReset();
    enterDigits(0, 0, 0, 0);
    pulseButton(0, 1);
    cycle();
    checks++;
    if (sound_a !== 1'b1) begin
      failures++; $display("[TB] FAIL async_pre_sound got=%b exp=1", sound_a);
    end
    pressKey(1);
    pressKey(2);
    checks++;
    if (dispObs !== 32'h3030_3132) begin
      failures++; $display("[TB] FAIL async_pre_disp got=%h exp=%h", dispObs, 32'h3030_3132);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (dispObs !== 32'h3030_3030 || sound_a !== 1'b0) begin
      failures++; $display("[TB] FAIL async_reset got=%h/%b exp=%h/0", dispObs, sound_a, 32'h3030_3030);
    end
    doReset();
  endtask

  task automatic test_back_to_back();
    step_t plan[$];
    step_t s;
    int h, m, sel, idle;
    bit f;
    doReset();
    for (int it = 0; it < 40; it++) begin
      f = ($urandom_range(0, 3) == 0);
      h = int'($urandom_range(0, 29));
      m = int'($urandom_range(0, 69));
      for (int d = 0; d < 4; d++) begin
        int dig;
        dig = (d == 0) ? h / 10 : (d == 1) ? h % 10 : (d == 2) ? m / 10 : m % 10;
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) plan.push_back('{4'(dig), 1'b0, 1'b0, f});
        for (int k = 0; k < int'($urandom_range(1, 2)); k++) plan.push_back('{4'($urandom_range(10, 15)), 1'b0, 1'b0, f});
      end
      sel = int'($urandom_range(0, 3));
      if (sel != 3) plan.push_back('{4'd10, sel != 1, sel != 0, f});
      idle = ($urandom_range(0, 4) == 0) ? TO_CYC + 4 : int'($urandom_range(0, 12));
      for (int k = 0; k < idle; k++) plan.push_back('{4'd10, 1'b0, ($urandom_range(0, 5) == 0), f});
      while (plan.size() > 0) begin
        s = plan.pop_front();
        key = s.k; time_button = s.t; alarm_button = s.a; fast_watch = s.f;
        cycle();
        checks++;
        if (dispObs !== expDisp || sound_a !== expSound) begin
          failures++; $display("[TB] FAIL random it=%0d got=%h/%b exp=%h/%b", it, dispObs, sound_a, expDisp, expSound);
        end
      end
    end
    key = 4'd10; time_button = 0; alarm_button = 0; fast_watch = 0;
  endtask

  initial begin
    test_reset();
    test_set_time();
    test_fast_wrap();
    test_alarm();
    test_invalid();
    test_timeout();
    test_both_buttons();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
